instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
//  Writes a program into the datapath instruction memory. The program arrives as a byte stream
//    over a valid/ready handshake; instruction fetch is the reader on the other side.
//  Packs bytes into 32-bit little-endian words and writes them to consecutive word addresses.
//  Holds the datapath in reset until a zero word (end-of-program marker) has been stored.
// PARAMETERS
//  DEPTH   64  instruction memory capacity in 32-bit words (power of two, >=2)
//  ADDR_W  8   byte-address width of mem_addr; must satisfy 2**ADDR_W >= 4*DEPTH
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high
//  start        in   1       one-cycle pulse; re-arms the loader from DONE or ERROR
//  byte_valid   in   1       byte_data holds a valid byte
//  byte_data    in   8       program byte, least significant byte of each word first
//  byte_ready   out  1       loader accepts a byte this cycle
//  mem_we       out  1       instruction memory write strobe, one cycle per word
//  mem_addr     out  ADDR_W  byte address of the write (word_idx*4)
//  mem_wdata    out  32      assembled instruction word
//  cpu_reset    out  1       reset for the datapath; high while the loader is not DONE
//  done         out  1       program loaded, terminator stored
//  error        out  1       overflow (or checksum mismatch, see CONFIGURATION)
//  word_count   out  ADDR_W  words written so far, terminator included
// BEHAVIOUR
//  Reset (async, any state): state=ASSEMBLE, byte_idx=0, word_idx=0, mem_we=0, mem_addr=0,
//    mem_wdata=0, byte_ready=1, cpu_reset=1, done=0, error=0, word_count=0.
//  Reset in the middle of a word discards the partial word. Memory contents are not touched.
//  Byte handshake: a byte transfers on a rising edge when byte_valid && byte_ready.
//    byte_data must be stable while byte_valid=1 and byte_ready=0.
//  States:
//  ASSEMBLE: byte_ready=1. Each accepted byte goes into lane byte_idx of the shift register,
//    then byte_idx increments. On the 4th byte (byte_idx==3) the next state is WRITE.
//  WRITE (exactly one cycle): byte_ready=0, mem_we=1, mem_addr=word_idx<<2,
//    mem_wdata=assembled word, word_count increments at the end of the cycle.
//      word==0                              -> DONE (the terminator is written so fetch halts)
//      word!=0 and word_idx==DEPTH-1        -> ERROR (no room for a terminator; write still occurs)
//      otherwise                            -> word_idx++, byte_idx=0, back to ASSEMBLE
//  DONE: byte_ready=0, done=1, cpu_reset=0 from the first DONE cycle. Incoming bytes are stalled.
//  ERROR: byte_ready=0, error=1, cpu_reset stays 1.
//  Latency: mem_we is asserted in the cycle after the 4th byte is accepted.
//    Maximum throughput is 4 bytes per 5 cycles.
//  start in DONE or ERROR -> ASSEMBLE next cycle with all counters cleared, done=0, error=0,
//    cpu_reset=1. start in ASSEMBLE or WRITE is ignored.
//  start together with byte_valid in DONE: the byte is not accepted (byte_ready=0 that cycle).
//  word_idx and word_count never wrap; ERROR is entered before word_idx could exceed DEPTH-1.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - After the terminator WRITE, the FSM enters CHECK (byte_ready=1) and accepts one more byte.
//    - If that byte equals the XOR of all bytes accepted since reset/start (terminator included)
//      -> DONE; otherwise -> ERROR.
//    - cpu_reset stays 1 during CHECK.
//  LOADER_CHECKSUM_EN undefined: CHECK does not exist; the terminator goes straight to DONE.
// TESTING
//  1. Reset, then stream 13 00 10 00 | 00 00 00 00 -> WRITE addr 0 data 0x00100013,
//     WRITE addr 4 data 0; done=1, cpu_reset=0, word_count=2.
//  2. byte_valid toggled every other cycle over the same stream -> identical writes,
//     no byte lost or duplicated.
//  3. DEPTH=4, four nonzero words -> 4th write at addr 12, then error=1, cpu_reset=1,
//     byte_ready=0.
//  4. reset pulsed after 2 bytes of word 1 -> outputs at reset values; restarted stream
//     writes word 1 at addr 0.
//  5. From DONE, pulse start, stream 6F 00 00 00 00 00 00 00 -> writes 0x0000006F@0, 0@4, done=1.
//  6. LOADER_CHECKSUM_EN, case 1 followed by 0x03 -> done=1; followed by 0x04 -> error=1.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes them to instruction
// memory, holds the datapath in reset until a zero terminator word is stored. Option: LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_ASSEMBLE,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_word_count;
    logic [31:0]       r_word;
    logic              w_accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path can infer a latch.
        w_next_state = r_state;
        byte_ready   = 1'b0;
        mem_we       = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_reset    = 1'b1;

        case (r_state)
            S_ASSEMBLE: byte_ready = 1'b1;
            S_WRITE:    mem_we     = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERROR:    error      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:    byte_ready = 1'b1;
`endif
            default: ;
        endcase

        w_accept = byte_valid && byte_ready;

        case (r_state)
            S_ASSEMBLE: if (w_accept && r_byte_idx == 2'd3) w_next_state = S_WRITE;
            S_WRITE: begin
                if (r_word == 32'd0)
`ifdef LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_DONE;
`endif
                else if (r_word_idx == LAST_IDX)
                    w_next_state = S_ERROR;
                else
                    w_next_state = S_ASSEMBLE;
            end
            S_DONE, S_ERROR: if (start) w_next_state = S_ASSEMBLE;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (w_accept) w_next_state = (byte_data == r_csum) ? S_DONE : S_ERROR;
`endif
            default: w_next_state = S_ASSEMBLE;
        endcase
    end

    // The instruction memory lives outside this block; reset only clears the loader's own state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_ASSEMBLE;
            r_byte_idx   <= '0;
            r_word_idx   <= '0;
            r_word_count <= '0;
            r_word       <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            case (r_state)
                S_ASSEMBLE: if (w_accept) begin
                    r_word[{r_byte_idx, 3'b000} +: 8] <= byte_data;
                    r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    r_csum     <= r_csum ^ byte_data;
`endif
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + 1'b1;
                    if (w_next_state == S_ASSEMBLE) r_word_idx <= r_word_idx + 1'b1;
                end
                S_DONE, S_ERROR: if (start) begin
                    r_byte_idx   <= '0;
                    r_word_idx   <= '0;
                    r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                    r_csum       <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = {r_word_idx[ADDR_W-3:0], 2'b00};
    assign mem_wdata  = r_word;
    assign word_count = r_word_count;

endmodule
